// File: rtl/fpu_addsub_seq_if.sv
// Issue-side handshake plus the port pair to the shared 28-bit mantissa ALU.
// The sequencer owns the ALU operand lines; the ALU answers combinationally.
interface fpu_addsub_seq_if;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        ovf;
  logic        inv;
  logic [27:0] alu_augend;
  logic [27:0] alu_addend;
  logic        alu_aos;
  logic [27:0] alu_result;
  logic        alu_c;

  modport slave (
    input  start, op, a, b, alu_result, alu_c,
    output busy, done, result, ovf, inv, alu_augend, alu_addend, alu_aos
  );

  modport master (
    output start, op, a, b, alu_result, alu_c,
    input  busy, done, result, ovf, inv, alu_augend, alu_addend, alu_aos
  );
endinterface

// File: rtl/fpu_addsub_seq.sv
// Multi-cycle binary32 add/sub sequencer: swap, align, add, normalize, RNE round,
// borrowing the external 28-bit ALU for both the mantissa add and the round increment.
module fpu_addsub_seq (
  input  logic             clk,
  input  logic             rst_n,
  fpu_addsub_seq_if.slave  bus
);
  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;

  state_t      state, state_nxt;
  logic        sign_r, sub_eff, inv_pend, inv_r, ovf_r;
  logic [9:0]  exp_r;
  logic [7:0]  exp_b;
  logic [27:0] mant_a, mant_b, sum;
  logic [31:0] result_r;

  // denormals are flushed: exponent 0 yields a zero mantissa
  function automatic logic [27:0] unpack(input logic [30:0] f);
    return (f[30:23] == 8'd0) ? 28'd0 : {2'b01, f[22:0], 3'b000};
  endfunction

  logic        accept, swap, sign_y;
  logic [30:0] op_x, op_y;
  assign accept = bus.start && (state == S_IDLE || state == S_DONE);
  assign sign_y = bus.b[31] ^ bus.op;
  assign swap   = bus.b[30:0] > bus.a[30:0];
  assign op_x   = swap ? bus.b[30:0] : bus.a[30:0];
  assign op_y   = swap ? bus.a[30:0] : bus.b[30:0];

  logic [7:0]  d;
  logic [27:0] shifted, lost_mask;
  logic        lost;
  assign d         = exp_r[7:0] - exp_b;
  assign shifted   = mant_b >> d;
  assign lost_mask = ~(28'hFFFFFFF << d);
  assign lost      = |(mant_b & lost_mask);

  logic        inc, rcarry;
  logic [22:0] rfrac;
  logic [9:0]  rexp;
  assign inc    = sum[2] & (sum[1] | sum[0] | sum[3]);
  assign rcarry = bus.alu_result[27] | bus.alu_c;
  assign rfrac  = rcarry ? bus.alu_result[26:4] : bus.alu_result[25:3];
  assign rexp   = exp_r + {9'd0, rcarry};

  always_comb begin
    state_nxt      = state;
    bus.alu_augend = '0;
    bus.alu_addend = '0;
    bus.alu_aos    = 1'b0;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_ALIGN;
      S_ALIGN: state_nxt = inv_pend ? S_DONE : S_ADD;
      S_ADD: begin
        bus.alu_augend = mant_a;
        bus.alu_addend = mant_b;
        bus.alu_aos    = sub_eff;
        state_nxt      = S_NORM;
      end
      S_NORM: begin
        if (sum == 28'd0)             state_nxt = S_DONE;
        else if (sum[27] || sum[26])  state_nxt = S_ROUND;
        else if (exp_r > 10'd1)       state_nxt = S_NORM;
        else                          state_nxt = S_DONE;
      end
      S_ROUND: begin
        bus.alu_augend = sum;
        bus.alu_addend = inc ? 28'h8 : 28'h0;
        state_nxt      = S_DONE;
      end
      S_DONE:  state_nxt = bus.start ? S_ALIGN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      sign_r   <= 1'b0;
      sub_eff  <= 1'b0;
      inv_pend <= 1'b0;
      inv_r    <= 1'b0;
      ovf_r    <= 1'b0;
      exp_r    <= '0;
      exp_b    <= '0;
      mant_a   <= '0;
      mant_b   <= '0;
      sum      <= '0;
      result_r <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sign_r   <= swap ? sign_y : bus.a[31];
        sub_eff  <= bus.op ^ bus.a[31] ^ bus.b[31];
        exp_r    <= {2'b00, op_x[30:23]};
        exp_b    <= op_y[30:23];
        mant_a   <= unpack(op_x);
        mant_b   <= unpack(op_y);
        inv_pend <= (bus.a[30:23] == 8'hFF) || (bus.b[30:23] == 8'hFF);
        inv_r    <= 1'b0;
        ovf_r    <= 1'b0;
      end
      case (state)
        S_ALIGN: begin
          if (inv_pend) begin
            inv_r    <= 1'b1;
            result_r <= 32'h7FC00000;
          end else if (d >= 8'd27) mant_b <= {27'd0, |mant_b};
          else                     mant_b <= {shifted[27:1], shifted[0] | lost};
        end
        S_ADD: sum <= bus.alu_result;
        S_NORM: begin
          if (sum == 28'd0) result_r <= 32'd0;
          else if (sum[27]) begin
            sum   <= {1'b0, sum[27:2], sum[1] | sum[0]};
            exp_r <= exp_r + 10'd1;
          end else if (sum[26]) begin
            sum <= sum;
          end else if (exp_r > 10'd1) begin
            sum   <= {sum[26:0], 1'b0};
            exp_r <= exp_r - 10'd1;
          end else result_r <= {sign_r, 31'd0};
        end
        S_ROUND: begin
          if (rexp >= 10'd255) begin
            result_r <= {sign_r, 8'hFF, 23'd0};
            ovf_r    <= 1'b1;
          end else result_r <= {sign_r, rexp[7:0], rfrac};
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state == S_ALIGN) || (state == S_ADD) || (state == S_NORM) || (state == S_ROUND);
  assign bus.done   = (state == S_DONE);
  assign bus.result = result_r;
  assign bus.ovf    = ovf_r;
  assign bus.inv    = inv_r;
endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Random + directed check of fpu_addsub_seq against an exact-arithmetic binary32 model.
module tb_fpu_addsub_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpu_addsub_seq_if bus();
  fpu_addsub_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // external ALU: combinational 28-bit add / subtract
  always_comb begin
    if (bus.alu_aos) {bus.alu_c, bus.alu_result} = {1'b0, bus.alu_augend} - {1'b0, bus.alu_addend};
    else             {bus.alu_c, bus.alu_result} = {1'b0, bus.alu_augend} + {1'b0, bus.alu_addend};
  end

  int total = 0;
  int bad = 0;
  logic [33:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, req);
    end
  endtask

  // exact sum on a 2^-149 grid, then RNE to 24 bits; returns {ovf, inv, result}
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input bit o);
    logic sx, sy, s;
    logic [7:0] ex, ey;
    logic [299:0] one, vx, vy, mag, q, rem, half;
    int p, e, sh;
    one = 300'd1;
    sx = x[31]; sy = y[31] ^ o; ex = x[30:23]; ey = y[30:23];
    if (ex == 8'hFF || ey == 8'hFF) return {2'b01, 32'h7FC00000};
    vx = '0; vy = '0;
    if (ex != 0) vx = ((one << 23) | 300'(x[22:0])) << (int'(ex) - 1);
    if (ey != 0) vy = ((one << 23) | 300'(y[22:0])) << (int'(ey) - 1);
    if (sx == sy)      begin mag = vx + vy; s = sx; end
    else if (vx >= vy) begin mag = vx - vy; s = sx; end
    else               begin mag = vy - vx; s = sy; end
    if (mag == 0) return 34'd0;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e = p - 22;
    if (e < 1) return {2'b00, s, 31'd0};
    sh = p - 23;
    q = mag >> sh;
    if (sh > 0) begin
      rem  = mag & ((one << sh) - 1);
      half = one << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
    end
    if (q[24]) begin q = q >> 1; e++; end
    if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
    return {2'b00, s, 8'(e), q[22:0]};
  endfunction

  // single compare process: every done pulse is checked against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_done act=1 exp=0");
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        chk("result", 64'(bus.result), 64'(e[31:0]));
        chk("ovf", 64'(bus.ovf), 64'(e[33]));
        chk("inv", 64'(bus.inv), 64'(e[32]));
        chk("busy_at_done", 64'(bus.busy), 64'd0);
      end
    end
  end

  // issue one op from a negedge; lat<0 means "any legal latency"
  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input bit o,
                       input int lat, input bit has_lit, input logic [33:0] lit, input bit poke);
    logic [33:0] e;
    int c, w;
    w = 0;
    while (bus.busy && w < 40) begin @(negedge clk); w++; end
    if (w == 40) begin total++; bad++; $display("FAIL idle_wait act=busy exp=idle"); end
    e = model(x, y, o);
    if (has_lit) chk("model_pin", 64'(e), 64'(lit));
    exp_q.push_back(e);
    bus.a = x; bus.b = y; bus.op = o; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_accept", 64'(bus.busy), 64'd1);
    chk("flags_cleared", 64'({bus.ovf, bus.inv}), 64'd0);
    c = 0;
    while (!bus.done && c < 40) begin
      @(negedge clk);
      c++;
      if (poke && c == 1) begin
        bus.start = 1'b1; bus.a = 32'h40400000; bus.b = 32'h40400000; bus.op = 1'b0;
      end else if (poke && c == 2) bus.start = 1'b0;
    end
    if (c == 40) begin
      total++; bad++;
      $display("FAIL done_timeout act=none exp=done");
      void'(exp_q.pop_front());
    end else if (lat >= 0) chk("latency", 64'(c), 64'(lat));
    else begin
      total++;
      if (c < 1 || c > 31) begin bad++; $display("FAIL latency_range act=%0d exp=1..31", c); end
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [7:0] ea, eb;
    bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
    #12;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_flags", 64'({bus.ovf, bus.inv}), 64'd0);
    chk("rst_alu", 64'({bus.alu_augend, bus.alu_addend, bus.alu_aos}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    do_op(32'h3F800000, 32'h3F800000, 1'b0, 4, 1'b1, {2'b00, 32'h40000000}, 1'b0);
    do_op(32'h3FC00000, 32'h3F800000, 1'b1, 5, 1'b1, {2'b00, 32'h3F000000}, 1'b0);
    do_op(32'h3F800000, 32'h3F800000, 1'b1, 3, 1'b1, {2'b00, 32'h00000000}, 1'b0);
    do_op(32'h3F800000, 32'h33800000, 1'b0, 4, 1'b1, {2'b00, 32'h3F800000}, 1'b0);
    do_op(32'h3F800000, 32'h33C00000, 1'b0, 4, 1'b1, {2'b00, 32'h3F800001}, 1'b0);
    do_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4, 1'b1, {2'b10, 32'h7F800000}, 1'b0);
    do_op(32'h3F800000, 32'h3F800000, 1'b0, 4, 1'b1, {2'b00, 32'h40000000}, 1'b0);
    do_op(32'h7F800000, 32'h3F800000, 1'b0, 1, 1'b1, {2'b01, 32'h7FC00000}, 1'b0);
    do_op(32'hC0000000, 32'h3F800000, 1'b0, 5, 1'b1, {2'b00, 32'hBF800000}, 1'b0);
    // start pulsed while busy must not produce a second done
    do_op(32'h40000000, 32'h3F800000, 1'b0, 4, 1'b1, {2'b00, 32'h40400000}, 1'b1);
    repeat (8) @(negedge clk);

    for (int n = 0; n < 400; n++) begin
      ea = ($urandom_range(0, 40) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
      if ($urandom_range(0, 1) == 1) eb = (ea > 8'd250) ? ea : ea + 8'($urandom_range(0, 2));
      else eb = 8'($urandom_range(0, 254));
      ra = {1'($urandom), ea, 23'($urandom)};
      rb = {1'($urandom), eb, 23'($urandom)};
      if ($urandom_range(0, 9) == 0) rb = {~ra[31], ra[30:0]};
      if ($urandom_range(0, 9) == 0) rb[22:0] = {ra[22:4], 4'($urandom)};
      do_op(ra, rb, 1'($urandom), -1, 1'b0, 34'd0, 1'b0);
    end
    repeat (3) @(negedge clk);

    // asynchronous abort two cycles into an operation
    bus.a = 32'h3F800000; bus.b = 32'h3F800000; bus.op = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.start = 1'b0;
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_result", 64'(bus.result), 64'd0);
    chk("abort_flags", 64'({bus.ovf, bus.inv}), 64'd0);
    chk("abort_alu", 64'({bus.alu_augend, bus.alu_addend, bus.alu_aos}), 64'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    repeat (10) @(negedge clk);
    do_op(32'h40400000, 32'hC0400000, 1'b0, 3, 1'b1, {2'b00, 32'h00000000}, 1'b0);
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL leftover_expect act=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
